// File: rtl/disp_pkg.sv
// Shared widths and types for the dispatch-queue scatter stage.
// Defaults mirror a 4-wide dequeue feeding 3 issue queues of 8 entries each.
package disp_pkg;

    localparam int unsigned DISP_INPORT_NUM   = 4;
    localparam int unsigned DISP_OUTPORT_NUM  = 3;
    localparam int unsigned DISP_CREDIT_DEPTH = 8;
    localparam int unsigned DISP_PERF_W       = 32;

    // Never returns 0 so single-target configurations still get a legal vector.
    function automatic int unsigned disp_clog2(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned PORT_W   = disp_clog2(DISP_OUTPORT_NUM);
    localparam int unsigned CREDIT_W = disp_clog2(DISP_CREDIT_DEPTH + 1);

    typedef logic [CREDIT_W-1:0] credit_t;

endpackage

// File: rtl/disp_credit_cnt.sv
// Credit counter for one issue-queue target. It mirrors that queue's free entries.
// The count is decremented on issue, incremented on return, and reloaded on flush.
module disp_credit_cnt
    import disp_pkg::*;
#(
    parameter int unsigned CREDIT_DEPTH = DISP_CREDIT_DEPTH,
    parameter int unsigned CW           = disp_clog2(CREDIT_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_issue,
    input  logic          i_ret,
    output logic [CW-1:0] o_credit
);

    localparam logic [CW-1:0] FULL = CW'(CREDIT_DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;

    // Returns arriving in a flush cycle are dropped because the issue queue empties as well.
    always_comb begin
        cnt_d = cnt_q;
        if (i_flush) begin
            cnt_d = FULL;
        end else if (i_issue && !i_ret) begin
            cnt_d = cnt_q - CW'(1);
        end else if (!i_issue && i_ret && (cnt_q != FULL)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= FULL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_credit = cnt_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(i_ret && !i_issue && !i_flush && (cnt_q == FULL)));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(i_issue && !i_flush && (cnt_q == '0)));

endmodule

// File: rtl/disp_scatter.sv
// Dispatch-queue consumer: grants an in-order, credit-gated prefix and scatters it onto the issue-queue ports.
// Define DISP_SCATTER_PERF_EN to add the stall counters o_perf_stall_credit and o_perf_stall_conflict.
module disp_scatter
    import disp_pkg::*;
#(
    parameter int unsigned INPORT_NUM   = DISP_INPORT_NUM,
    parameter int unsigned OUTPORT_NUM  = DISP_OUTPORT_NUM,
    parameter int unsigned CREDIT_DEPTH = DISP_CREDIT_DEPTH,
    parameter type         dtype        = logic,
    parameter int unsigned PW           = disp_clog2(OUTPORT_NUM),
    parameter int unsigned CW           = disp_clog2(CREDIT_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_stall,
    input  logic [INPORT_NUM-1:0]  i_can_deq,
    input  dtype                   i_deq_data [INPORT_NUM],
    input  logic [PW-1:0]          i_deq_port [INPORT_NUM],
    output logic [INPORT_NUM-1:0]  o_deq_req,
    output logic [OUTPORT_NUM-1:0] o_issue_vld,
    output dtype                   o_issue_data [OUTPORT_NUM],
    input  logic [OUTPORT_NUM-1:0] i_credit_ret
`ifdef DISP_SCATTER_PERF_EN
    ,
    output logic [DISP_PERF_W-1:0] o_perf_stall_credit,
    output logic [DISP_PERF_W-1:0] o_perf_stall_conflict
`endif
);

    logic [CW-1:0]          credit_cnt [OUTPORT_NUM];
    logic [INPORT_NUM-1:0]  grant;
    logic [OUTPORT_NUM-1:0] issue_vld_d, issue_vld_q;
    dtype                   issue_data_d [OUTPORT_NUM];
    dtype                   issue_data_q [OUTPORT_NUM];
    logic                   blk_credit, blk_conflict;

    // The chain breaks at the first entry that lacks credit or collides with an older grant.
    // Credit is read from the register, so a same-cycle return cannot unblock an entry.
    always_comb begin
        logic [OUTPORT_NUM-1:0] used;
        logic                   chain;
        logic                   in_range;
        logic                   has_credit;
        logic                   conflict;
        grant        = '0;
        issue_vld_d  = '0;
        used         = '0;
        blk_credit   = 1'b0;
        blk_conflict = 1'b0;
        in_range     = 1'b0;
        has_credit   = 1'b0;
        conflict     = 1'b0;
        chain        = rst && !i_stall && !i_flush;
        for (int p = 0; p < OUTPORT_NUM; p++) begin
            issue_data_d[p] = issue_data_q[p];
        end
        for (int k = 0; k < INPORT_NUM; k++) begin
            in_range   = int'(i_deq_port[k]) < int'(OUTPORT_NUM);
            has_credit = in_range && (credit_cnt[i_deq_port[k]] != '0);
            conflict   = in_range && used[i_deq_port[k]];
            if (chain && i_can_deq[k]) begin
                if (has_credit && !conflict) begin
                    grant[k]                      = 1'b1;
                    used[i_deq_port[k]]           = 1'b1;
                    issue_vld_d[i_deq_port[k]]    = 1'b1;
                    issue_data_d[i_deq_port[k]]   = i_deq_data[k];
                end else begin
                    blk_credit   = !has_credit;
                    blk_conflict = has_credit && conflict;
                    chain        = 1'b0;
                end
            end else begin
                chain = 1'b0;
            end
        end
    end

    assign o_deq_req = grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_vld_q <= '0;
            for (int p = 0; p < OUTPORT_NUM; p++) begin
                issue_data_q[p] <= '0;
            end
        end else begin
            issue_vld_q  <= issue_vld_d;
            issue_data_q <= issue_data_d;
        end
    end

    assign o_issue_vld  = issue_vld_q;
    assign o_issue_data = issue_data_q;

    for (genvar p = 0; p < OUTPORT_NUM; p++) begin : g_credit
        disp_credit_cnt #(
            .CREDIT_DEPTH (CREDIT_DEPTH),
            .CW           (CW)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .i_flush  (i_flush),
            .i_issue  (issue_vld_d[p]),
            .i_ret    (i_credit_ret[p]),
            .o_credit (credit_cnt[p])
        );
    end

`ifdef DISP_SCATTER_PERF_EN
    logic [DISP_PERF_W-1:0] perf_credit_q, perf_conflict_q;

    // Counters saturate rather than wrap, and a flush does not clear them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_credit_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            if (blk_credit && (perf_credit_q != '1)) begin
                perf_credit_q <= perf_credit_q + DISP_PERF_W'(1);
            end
            if (blk_conflict && (perf_conflict_q != '1)) begin
                perf_conflict_q <= perf_conflict_q + DISP_PERF_W'(1);
            end
        end
    end

    assign o_perf_stall_credit   = perf_credit_q;
    assign o_perf_stall_conflict = perf_conflict_q;
`else
    logic unused_perf;
    assign unused_perf = blk_credit ^ blk_conflict;
`endif

    a_prefix: assert property (@(posedge clk) disable iff (!rst)
        ((i_can_deq & (i_can_deq + 1'b1)) == '0));

    for (genvar k = 0; k < INPORT_NUM; k++) begin : g_port_chk
        a_port_range: assert property (@(posedge clk) disable iff (!rst)
            i_can_deq[k] |-> (int'(i_deq_port[k]) < int'(OUTPORT_NUM)));
    end

endmodule

// File: tb/tb_disp_scatter.sv
// Directed testbench for disp_scatter: prefix grant, credits, flush, async reset.
// Define DISP_SCATTER_PERF_EN to also check the stall counters.
module tb_disp_scatter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush;
    logic       stall;
    logic [3:0] canDeq;
    logic [7:0] deqData [4];
    logic [1:0] deqPort [4];
    logic [3:0] deqReq;
    logic [2:0] issueVld;
    logic [7:0] issueData [3];
    logic [2:0] creditRet;
`ifdef DISP_SCATTER_PERF_EN
    logic [31:0] perfCredit;
    logic [31:0] perfConflict;
`endif

    int checks   = 0;
    int failures = 0;

    disp_scatter #(
        .INPORT_NUM   (4),
        .OUTPORT_NUM  (3),
        .CREDIT_DEPTH (8),
        .dtype        (logic [7:0])
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (flush),
        .i_stall      (stall),
        .i_can_deq    (canDeq),
        .i_deq_data   (deqData),
        .i_deq_port   (deqPort),
        .o_deq_req    (deqReq),
        .o_issue_vld  (issueVld),
        .o_issue_data (issueData),
        .i_credit_ret (creditRet)
`ifdef DISP_SCATTER_PERF_EN
        ,
        .o_perf_stall_credit   (perfCredit),
        .o_perf_stall_conflict (perfConflict)
`endif
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] can, input logic [1:0] p0, input logic [1:0] p1,
                                 input logic [1:0] p2, input logic [1:0] p3, input logic [2:0] ret,
                                 input logic fl, input logic st, input logic [7:0] base);
        canDeq     = can;
        deqPort[0] = p0;
        deqPort[1] = p1;
        deqPort[2] = p2;
        deqPort[3] = p3;
        creditRet  = ret;
        flush      = fl;
        stall      = st;
        for (int k = 0; k < 4; k++) begin
            deqData[k] = base + 8'(k);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCredits(input string tag, input int c0, input int c1, input int c2);
        checkOutput({tag, "_c0"}, 32'(dut.credit_cnt[0]), c0);
        checkOutput({tag, "_c1"}, 32'(dut.credit_cnt[1]), c1);
        checkOutput({tag, "_c2"}, 32'(dut.credit_cnt[2]), c2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(4'b1111, 2'd0, 2'd1, 2'd2, 2'd0, 3'b000, 1'b0, 1'b0, 8'h10);
        #1 rst = 1'b0;
        #2;
        checkOutput("rst_deq", 32'(deqReq), 32'h0);
        checkOutput("rst_vld", 32'(issueVld), 32'h0);
        checkOutput("rst_data0", 32'(issueData[0]), 32'h0);
        checkCredits("rst", 8, 8, 8);

        // Four ready entries, the youngest collides with entry 0 on port 0.
        @(negedge clk) rst = 1'b1;
        #1 checkOutput("t1_deq", 32'(deqReq), 32'b0111);
        tick();
        checkOutput("t1_vld", 32'(issueVld), 32'b111);
        checkOutput("t1_d0", 32'(issueData[0]), 32'h10);
        checkOutput("t1_d1", 32'(issueData[1]), 32'h11);
        checkOutput("t1_d2", 32'(issueData[2]), 32'h12);
        checkCredits("t1", 7, 7, 7);

        // Drain port 0 down to zero credit.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4'b0001, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 8'h20 + 8'(i));
            #1 checkOutput("t2_drain_deq", 32'(deqReq), 32'b0001);
            tick();
        end
        checkOutput("t2_drain_vld", 32'(issueVld), 32'b001);
        checkOutput("t2_drain_d0", 32'(issueData[0]), 32'h26);
        checkCredits("t2_drain", 0, 7, 7);

        applyStimulus(4'b0011, 2'd1, 2'd0, 2'd0, 2'd0, 3'b001, 1'b0, 1'b0, 8'h30);
        #1 checkOutput("t2_blk_deq", 32'(deqReq), 32'b0001);
        tick();
        checkOutput("t2_blk_vld", 32'(issueVld), 32'b010);
        checkOutput("t2_blk_d1", 32'(issueData[1]), 32'h30);
        checkCredits("t2_blk", 1, 6, 7);

        applyStimulus(4'b0001, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 8'h31);
        #1 checkOutput("t2_ret_deq", 32'(deqReq), 32'b0001);
        tick();
        checkOutput("t2_ret_vld", 32'(issueVld), 32'b001);
        checkOutput("t2_ret_d0", 32'(issueData[0]), 32'h31);
        checkCredits("t2_ret", 0, 6, 7);

        // Same-port pair blocks a younger entry that has a free port.
        applyStimulus(4'b0111, 2'd2, 2'd2, 2'd1, 2'd0, 3'b000, 1'b0, 1'b0, 8'h40);
        #1 checkOutput("t3_deq", 32'(deqReq), 32'b0001);
        tick();
        checkOutput("t3_vld", 32'(issueVld), 32'b100);
        checkOutput("t3_d2", 32'(issueData[2]), 32'h40);
        checkOutput("t3_d0_hold", 32'(issueData[0]), 32'h31);
        checkCredits("t3", 0, 6, 6);

        applyStimulus(4'b0001, 2'd2, 2'd0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 8'h48);
        #1 checkOutput("stall_deq", 32'(deqReq), 32'b0000);
        tick();
        checkOutput("stall_vld", 32'(issueVld), 32'b000);
        checkCredits("stall", 0, 6, 6);

        // A return in the same cycle as the zero-credit attempt only helps next cycle.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0001, 2'd1, 2'd0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 8'h50 + 8'(i));
            tick();
        end
        checkCredits("t4_drain", 0, 0, 6);
        applyStimulus(4'b0001, 2'd1, 2'd0, 2'd0, 2'd0, 3'b010, 1'b0, 1'b0, 8'h60);
        #1 checkOutput("t4_zero_deq", 32'(deqReq), 32'b0000);
        tick();
        checkOutput("t4_zero_vld", 32'(issueVld), 32'b000);
        checkCredits("t4_zero", 0, 1, 6);
        #1 checkOutput("t4_next_deq", 32'(deqReq), 32'b0001);
        tick();
        checkOutput("t4_next_vld", 32'(issueVld), 32'b010);
        checkOutput("t4_next_d1", 32'(issueData[1]), 32'h60);
        checkCredits("t4_next", 0, 1, 6);
        applyStimulus(4'b0001, 2'd1, 2'd0, 2'd0, 2'd0, 3'b010, 1'b0, 1'b0, 8'h61);
        #1 checkOutput("t4_steady_deq", 32'(deqReq), 32'b0001);
        tick();
        checkOutput("t4_steady_d1", 32'(issueData[1]), 32'h61);
        checkCredits("t4_steady", 0, 1, 6);

        // Flush with mixed outstanding credits and returns that must be ignored.
        applyStimulus(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 3'b001, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(4'b0011, 2'd0, 2'd2, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 8'h70);
        #1 checkOutput("t5_pre_deq", 32'(deqReq), 32'b0011);
        tick();
        checkOutput("t5_pre_vld", 32'(issueVld), 32'b101);
        checkCredits("t5_pre", 0, 1, 5);
        applyStimulus(4'b0011, 2'd1, 2'd2, 2'd0, 2'd0, 3'b111, 1'b1, 1'b0, 8'h80);
        #1 checkOutput("t5_flush_deq", 32'(deqReq), 32'b0000);
        tick();
        checkOutput("t5_flush_vld", 32'(issueVld), 32'b000);
        checkOutput("t5_flush_d0", 32'(issueData[0]), 32'h70);
        checkCredits("t5_flush", 8, 8, 8);

        // Asynchronous reset in the middle of a cycle.
        applyStimulus(4'b0111, 2'd0, 2'd1, 2'd2, 2'd0, 3'b000, 1'b0, 1'b0, 8'h90);
        tick();
        checkOutput("t6_pre_vld", 32'(issueVld), 32'b111);
        #2 rst = 1'b0;
        #1;
        checkOutput("t6_rst_vld", 32'(issueVld), 32'b000);
        checkOutput("t6_rst_deq", 32'(deqReq), 32'b0000);
        checkOutput("t6_rst_d2", 32'(issueData[2]), 32'h0);
        applyStimulus(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 8'h00);
        @(negedge clk) rst = 1'b1;
        tick();
        checkOutput("t6_post_vld", 32'(issueVld), 32'b000);
        checkCredits("t6_post", 8, 8, 8);

        // Three credit-blocked cycles, then one port-conflict cycle.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b0001, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 8'hA0 + 8'(i));
            tick();
        end
        checkCredits("t7_drain", 0, 8, 8);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 8'hB0);
            #1 checkOutput("t7_blk_deq", 32'(deqReq), 32'b0000);
            tick();
        end
        applyStimulus(4'b0011, 2'd2, 2'd2, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 8'hC0);
        #1 checkOutput("t7_conf_deq", 32'(deqReq), 32'b0001);
        tick();
        checkOutput("t7_conf_vld", 32'(issueVld), 32'b100);
        applyStimulus(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 8'h00);
        tick();
`ifdef DISP_SCATTER_PERF_EN
        checkOutput("perf_credit", perfCredit, 32'd3);
        checkOutput("perf_conflict", perfConflict, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_scatter.md
Name: disp_scatter

Overview:
- Consumer end of the dispatch queue: reads up to INPORT_NUM in-order entries per cycle and scatters each one to its target issue-queue port.
- Dequeue is an in-order prefix. Admission is gated by per-port credit counters that mirror each issue queue's free entries.
- Output is one registered stage toward the issue queues.
- Sits between the dispatch queue and the issue queues.

Parameters:
- INPORT_NUM, 4, number of ordered dequeue ports read from the dispatch queue
- OUTPORT_NUM, 3, number of issue-queue ports (targets)
- CREDIT_DEPTH, 8, entries per issue queue; initial credit value per port
- dtype, logic, payload type carried per entry

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- i_flush  in  1  pipeline flush
- i_stall  in  1  backend stall (ROB/rename full); blocks all dequeue
- i_can_deq  in  INPORT_NUM  per-port entry valid from queue; prefix-contiguous
- i_deq_data  in  dtype[INPORT_NUM]  entry payloads, oldest at index 0
- i_deq_port  in  $clog2(OUTPORT_NUM)[INPORT_NUM]  target issue port per entry
- o_deq_req  out  INPORT_NUM  combinational dequeue acknowledge to queue
- o_issue_vld  out  OUTPORT_NUM  registered write-valid per issue queue
- o_issue_data  out  dtype[OUTPORT_NUM]  registered payload per issue queue
- i_credit_ret  in  OUTPORT_NUM  one credit returned per port (an issue-queue entry freed)

Behaviour:
- Reset (rst=0, async): o_issue_vld=0, o_issue_data=0, all credits=CREDIT_DEPTH. o_deq_req is combinational and is 0 while in reset.
- Per-entry grant k (combinational) requires all of:
  - i_can_deq[k];
  - grant[k-1] (entry 0 has no predecessor condition);
  - credit[i_deq_port[k]] > 0;
  - no older granted entry targets the same port this cycle;
  - !i_stall and !i_flush.
- o_deq_req = grant. The result is always a prefix (0001, 0011, ...). The first blocked entry blocks all younger entries.
- Output stage, next cycle after a grant: o_issue_vld[p]=1 and o_issue_data[p]=payload of the granted entry targeting p. Unused ports have vld=0 and hold their data. Latency is 1 cycle from o_deq_req to o_issue_vld.
- Credits, width $clog2(CREDIT_DEPTH+1):
  - next = cur - issued_this_cycle + i_credit_ret[p].
  - Issue and return in the same cycle leave the count unchanged.
  - A return at CREDIT_DEPTH saturates and fires an assertion.
  - Credit 0 with a same-cycle return does NOT grant that cycle, because the return is visible next cycle.
- Flush:
  - o_deq_req=0 in that cycle; o_issue_vld cleared next cycle.
  - Credits reload to CREDIT_DEPTH; i_credit_ret in the flush cycle is ignored (issue queues flush too).
- Assertions:
  - i_can_deq is prefix-contiguous.
  - i_deq_port < OUTPORT_NUM for every valid entry.
- No FSM beyond the credit counters and output register; throughput is up to min(INPORT_NUM, OUTPORT_NUM) entries/cycle.

Optional Feature:
- Macro DISP_SCATTER_PERF_EN.
- Defined: adds outputs o_perf_stall_credit (32b) and o_perf_stall_conflict (32b).
  - Saturating counters, reset to 0, not cleared by flush.
  - Increment once per cycle in which i_can_deq[0]=1, !i_stall, !i_flush, and entry 0 (or the first ungranted valid entry) is blocked by zero credit, or respectively by a port conflict. Credit wins if both apply.
- Undefined: the ports and counters are absent; functional behaviour is identical.

Decomposition:
- Package disp_pkg holds:
  - localparam widths derived from OUTPORT_NUM/CREDIT_DEPTH (port index width, credit width);
  - a typedef for the credit count.
- Natural sub-module: disp_credit_cnt, one instance per output port (credit register, issue/return/flush update, saturation assert).
- Grant/prefix logic and the output register stay in disp_scatter.

Test Plan:
- Reset then i_can_deq=1111, ports {0,1,2,0}, credits full -> o_deq_req=0111; next cycle o_issue_vld=111 with entries 0/1/2 on ports 0/1/2; credits 7,7,7.
- Port-0 credit driven to 0, then i_can_deq=0011, ports {1,0} -> o_deq_req=0001; entry 1 blocked; i_credit_ret[0]=1 -> entry granted the following cycle.
- i_can_deq=0111, ports {2,2,1} -> o_deq_req=0001; entry 2 blocked by in-order prefix despite free port 1.
- Credit 0 on port 1 with i_credit_ret[1]=1 and issue attempt in the same cycle -> no grant that cycle, grant the next; steady issue+return each cycle holds credit constant.
- i_flush with o_issue_vld=101 and credits {3,5,0} -> o_deq_req=0; next cycle o_issue_vld=000 and credits 8,8,8; same-cycle i_credit_ret ignored.
- rst asserted mid-stream (async) -> o_issue_vld=0 immediately; after release, credits=8 and no stale issue. With DISP_SCATTER_PERF_EN, check o_perf_stall_credit counts 3 after 3 credit-blocked cycles.
